// File: rtl/riscv_constants.sv
// rtl/riscv_constants.sv - architectural constants shared by the RISC-V core
package riscv_constants;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_INC   = 32'd4;

endpackage

// File: rtl/riscv_defs.sv
// rtl/riscv_defs.sv - shared state and trap-cause enumerations for the RISC-V core
package riscv_defs;

  typedef enum logic [2:0] {
    CTRL_FETCH  = 3'd0,
    CTRL_DECODE = 3'd1,
    CTRL_EXEC   = 3'd2,
    CTRL_WB     = 3'd3,
    CTRL_TRAP   = 3'd4
  } ctrl_state_e;

  typedef enum logic {
    TRAP_ILLEGAL  = 1'b0,
    TRAP_FETCH_TO = 1'b1
  } trap_cause_e;

endpackage

// File: rtl/riscv_ctrl_timeout.sv
// rtl/riscv_ctrl_timeout.sv - fetch wait counter; expired_o flags the last allowed wait cycle
module riscv_ctrl_timeout #(
  parameter int FETCH_TIMEOUT = 16,
  parameter int TO_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Depends only on the registered count so the FSM can consume it without a loop.
  generate
    if (FETCH_TIMEOUT == 0) begin : g_no_timeout
      assign expired_o = 1'b0;
    end else begin : g_timeout
      assign expired_o = (cnt_q == TO_W'(FETCH_TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// rtl/riscv_multicycle_ctrl.sv - FETCH/DECODE/EXEC/WB sequencer with sticky trap
// Optional cycle/retire counters are built when RISCV_CTRL_PERF_EN is defined.
module riscv_multicycle_ctrl
  import riscv_defs::*;
  import riscv_constants::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16,
  parameter int          TO_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  input  logic        dec_legal_i,
  input  logic        stall_i,
  output logic        rf_we_o,
  output logic [31:0] pc_o,
  output logic [2:0]  state_o,
  output logic        trap_o,
  output logic [31:0] trap_pc_o,
  output logic        trap_cause_o
`ifdef RISCV_CTRL_PERF_EN
  ,
  output logic [31:0] retired_o,
  output logic [31:0] cycles_o
`endif
);

  ctrl_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        trap_q, trap_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  trap_cause_e trap_cause_q, trap_cause_d;
  logic        to_clr, to_en, to_expired;

  riscv_ctrl_timeout #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT),
    .TO_W         (TO_W)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr      (to_clr),
    .en       (to_en),
    .expired_o(to_expired)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    trap_d       = trap_q;
    trap_pc_d    = trap_pc_q;
    trap_cause_d = trap_cause_q;
    to_clr       = 1'b1;
    to_en        = 1'b0;
    case (state_q)
      CTRL_FETCH: begin
        // A ready in the final allowed cycle takes priority over the timeout.
        if (imem_ready_i) begin
          inst_d  = imem_rdata_i;
          state_d = CTRL_DECODE;
        end else begin
          to_clr = 1'b0;
          to_en  = 1'b1;
          if (to_expired) begin
            state_d      = CTRL_TRAP;
            trap_d       = 1'b1;
            trap_pc_d    = pc_q;
            trap_cause_d = TRAP_FETCH_TO;
          end
        end
      end
      CTRL_DECODE: begin
        if (dec_legal_i) begin
          state_d = CTRL_EXEC;
        end else begin
          state_d      = CTRL_TRAP;
          trap_d       = 1'b1;
          trap_pc_d    = pc_q;
          trap_cause_d = TRAP_ILLEGAL;
        end
      end
      CTRL_EXEC: begin
        if (!stall_i) begin
          state_d = CTRL_WB;
        end
      end
      CTRL_WB: begin
        pc_d    = pc_q + PC_INC;
        state_d = CTRL_FETCH;
      end
      CTRL_TRAP: begin
        state_d = CTRL_TRAP;
      end
      default: begin
        state_d = CTRL_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CTRL_FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      trap_q       <= 1'b0;
      trap_pc_q    <= 32'h0;
      trap_cause_q <= TRAP_ILLEGAL;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      trap_q       <= trap_d;
      trap_pc_q    <= trap_pc_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  assign imem_req_o   = (state_q == CTRL_FETCH);
  assign imem_addr_o  = pc_q;
  assign rf_we_o      = (state_q == CTRL_WB);
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign state_o      = state_q;
  assign trap_o       = trap_q;
  assign trap_pc_o    = trap_pc_q;
  assign trap_cause_o = trap_cause_q;

`ifdef RISCV_CTRL_PERF_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d  = cycles_q + 32'd1;
    retired_d = retired_q;
    if (state_q == CTRL_WB) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= 32'h0;
      cycles_q  <= 32'h0;
    end else begin
      retired_q <= retired_d;
      cycles_q  <= cycles_d;
    end
  end

  assign retired_o = retired_q;
  assign cycles_o  = cycles_q;
`else
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb/tb_riscv_multicycle_ctrl.sv - vector table, corner sequences and random instruction stream
module tb_riscv_multicycle_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ADD = 32'h0000_0033;
  localparam int          TO  = 16;

  logic        clk;
  logic        rst, ready, legal, stall;
  logic [31:0] rdata;
  logic        req, we, trap, cause;
  logic [31:0] addr, inst, pc, tpc;
  logic [2:0]  state;

  logic        w_rst, w_ready, w_legal, w_stall;
  logic [31:0] w_rdata;
  logic        w_req, w_we, w_trap, w_cause;
  logic [31:0] w_addr, w_inst, w_pc, w_tpc;
  logic [2:0]  w_state;

`ifdef RISCV_CTRL_PERF_EN
  logic [31:0] retired, cycles, w_retired, w_cycles;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int exp_cycles = 0;
  int exp_retired = 0;

  riscv_multicycle_ctrl #(.RESET_PC(32'h0), .FETCH_TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ready_i(ready), .imem_rdata_i(rdata), .inst_o(inst),
    .dec_legal_i(legal), .stall_i(stall), .rf_we_o(we), .pc_o(pc),
    .state_o(state), .trap_o(trap), .trap_pc_o(tpc), .trap_cause_o(cause)
`ifdef RISCV_CTRL_PERF_EN
    , .retired_o(retired), .cycles_o(cycles)
`endif
  );

  riscv_multicycle_ctrl #(.RESET_PC(32'hFFFF_FFFC), .FETCH_TIMEOUT(TO), .TO_W(8)) dut_wrap (
    .clk(clk), .rst(w_rst), .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_ready_i(w_ready), .imem_rdata_i(w_rdata), .inst_o(w_inst),
    .dec_legal_i(w_legal), .stall_i(w_stall), .rf_we_o(w_we), .pc_o(w_pc),
    .state_o(w_state), .trap_o(w_trap), .trap_pc_o(w_tpc), .trap_cause_o(w_cause)
`ifdef RISCV_CTRL_PERF_EN
    , .retired_o(w_retired), .cycles_o(w_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance one edge; perf model tracks what the counters must read afterwards.
  task automatic tick();
    if (rst) begin
      exp_cycles  = 0;
      exp_retired = 0;
    end else begin
      exp_cycles++;
      if (state == 3'd3) exp_retired++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_perf();
`ifdef RISCV_CTRL_PERF_EN
    chk("cycles", cycles, exp_cycles);
    chk("retired", retired, exp_retired);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1; ready = 1'b0; legal = 1'b1; stall = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rst, rdy, legal, stall;
    logic [2:0]  e_state;
    logic        e_req, e_we, e_trap;
    logic [31:0] e_pc, e_inst;
  } vec_t;

  vec_t tbl [18];

  logic [31:0] pc_exp, inst_exp, data;
  int          w, s;
  bit          lg, trapped;

  initial begin
    rst = 1'b1; ready = 1'b0; legal = 1'b1; stall = 1'b0; rdata = ADD;
    w_rst = 1'b1; w_ready = 1'b0; w_legal = 1'b1; w_stall = 1'b0; w_rdata = ADD;

    //        rst  rdy  lgl  stl  state req we trap pc     inst
    tbl[0]  = '{1'b0,1'b1,1'b1,1'b0,3'd0,1'b1,1'b0,1'b0,32'd0,NOP};
    tbl[1]  = '{1'b0,1'b0,1'b1,1'b0,3'd1,1'b0,1'b0,1'b0,32'd0,ADD};
    tbl[2]  = '{1'b0,1'b0,1'b1,1'b0,3'd2,1'b0,1'b0,1'b0,32'd0,ADD};
    tbl[3]  = '{1'b0,1'b0,1'b1,1'b0,3'd3,1'b0,1'b1,1'b0,32'd0,ADD};
    tbl[4]  = '{1'b0,1'b0,1'b1,1'b0,3'd0,1'b1,1'b0,1'b0,32'd4,ADD};
    tbl[5]  = '{1'b0,1'b0,1'b1,1'b0,3'd0,1'b1,1'b0,1'b0,32'd4,ADD};
    tbl[6]  = '{1'b0,1'b0,1'b1,1'b0,3'd0,1'b1,1'b0,1'b0,32'd4,ADD};
    tbl[7]  = '{1'b0,1'b1,1'b1,1'b0,3'd0,1'b1,1'b0,1'b0,32'd4,ADD};
    tbl[8]  = '{1'b0,1'b0,1'b1,1'b0,3'd1,1'b0,1'b0,1'b0,32'd4,ADD};
    tbl[9]  = '{1'b0,1'b0,1'b1,1'b1,3'd2,1'b0,1'b0,1'b0,32'd4,ADD};
    tbl[10] = '{1'b0,1'b0,1'b1,1'b1,3'd2,1'b0,1'b0,1'b0,32'd4,ADD};
    tbl[11] = '{1'b0,1'b0,1'b1,1'b0,3'd2,1'b0,1'b0,1'b0,32'd4,ADD};
    tbl[12] = '{1'b0,1'b0,1'b1,1'b0,3'd3,1'b0,1'b1,1'b0,32'd4,ADD};
    tbl[13] = '{1'b0,1'b1,1'b1,1'b0,3'd0,1'b1,1'b0,1'b0,32'd8,ADD};
    tbl[14] = '{1'b0,1'b0,1'b0,1'b0,3'd1,1'b0,1'b0,1'b0,32'd8,ADD};
    tbl[15] = '{1'b0,1'b1,1'b1,1'b1,3'd4,1'b0,1'b0,1'b1,32'd8,ADD};
    tbl[16] = '{1'b1,1'b1,1'b1,1'b1,3'd4,1'b0,1'b0,1'b1,32'd8,ADD};
    tbl[17] = '{1'b0,1'b0,1'b1,1'b0,3'd0,1'b1,1'b0,1'b0,32'd0,NOP};

    tick();
    chk_perf();
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("tbl%0d.state", i), 32'(state), 32'(tbl[i].e_state));
      chk($sformatf("tbl%0d.req", i), 32'(req), 32'(tbl[i].e_req));
      chk($sformatf("tbl%0d.we", i), 32'(we), 32'(tbl[i].e_we));
      chk($sformatf("tbl%0d.trap", i), 32'(trap), 32'(tbl[i].e_trap));
      chk($sformatf("tbl%0d.pc", i), pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d.addr", i), addr, tbl[i].e_pc);
      chk($sformatf("tbl%0d.inst", i), inst, tbl[i].e_inst);
      if (tbl[i].e_trap) begin
        chk($sformatf("tbl%0d.trap_pc", i), tpc, 32'd8);
        chk($sformatf("tbl%0d.cause", i), 32'(cause), 32'd0);
      end
      rst = tbl[i].rst; ready = tbl[i].rdy; legal = tbl[i].legal; stall = tbl[i].stall;
      tick();
    end
    chk_perf();

    // Ready withheld: trap after exactly TO fetch cycles.
    do_reset();
    for (int i = 0; i < TO; i++) begin
      chk("to.fetch", 32'(state), 32'd0);
      tick();
    end
    chk("to.state", 32'(state), 32'd4);
    chk("to.trap", 32'(trap), 32'd1);
    chk("to.cause", 32'(cause), 32'd1);
    chk("to.trap_pc", tpc, 32'd0);
    chk("to.req", 32'(req), 32'd0);
    chk_perf();

    // Ready in the last allowed cycle wins over the timeout.
    do_reset();
    for (int i = 0; i < TO - 1; i++) tick();
    rdata = 32'hDEAD_BEEF;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("to_ready.state", 32'(state), 32'd1);
    chk("to_ready.trap", 32'(trap), 32'd0);
    chk("to_ready.inst", inst, 32'hDEAD_BEEF);

    // Reset mid-EXEC with the stall held.
    legal = 1'b1; stall = 1'b1; tick(); tick();
    chk("mid_exec.state", 32'(state), 32'd2);
    rst = 1'b1; tick(); rst = 1'b0; stall = 1'b0;
    chk("rst_exec.state", 32'(state), 32'd0);
    chk("rst_exec.pc", pc, 32'd0);
    chk("rst_exec.inst", inst, NOP);
    chk_perf();

    // Reset mid-FETCH with a ready in the reset cycle: the word is dropped.
    tick(); tick();
    rdata = 32'h1234_5678; ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; ready = 1'b0;
    chk("rst_fetch.state", 32'(state), 32'd0);
    chk("rst_fetch.inst", inst, NOP);
    chk("rst_fetch.pc", pc, 32'd0);
    chk_perf();

    // PC wraps from 0xFFFF_FFFC to 0 on the second instance.
    @(posedge clk); #1;
    w_rst = 1'b0; w_ready = 1'b1;
    chk("wrap.pc0", w_pc, 32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    chk("wrap.we", 32'(w_we), 32'd1);
    @(posedge clk); #1;
    chk("wrap.pc1", w_pc, 32'd0);
    chk("wrap.state", 32'(w_state), 32'd0);
`ifdef RISCV_CTRL_PERF_EN
    chk("wrap.retired", w_retired, 32'd1);
    chk("wrap.cycles", w_cycles, 32'd4);
`endif

    // Random instruction stream against a per-instruction schedule model.
    do_reset();
    pc_exp = 32'd0;
    for (int k = 0; k < 60; k++) begin
      w  = ($urandom % 10 == 0) ? int'($urandom_range(15, 18)) : int'($urandom_range(0, 4));
      s  = int'($urandom_range(0, 3));
      lg = ($urandom % 8) != 0;
      data = $urandom;
      trapped = 1'b0;
      for (int c = 0; ; c++) begin
        chk("rnd.fetch_state", 32'(state), 32'd0);
        chk("rnd.fetch_addr", addr, pc_exp);
        chk("rnd.fetch_req", 32'(req), 32'd1);
        stall = 1'($urandom); legal = 1'($urandom);
        if (c == w) begin
          ready = 1'b1; rdata = data;
          tick();
          ready = 1'b0;
          break;
        end
        ready = 1'b0; rdata = $urandom;
        tick();
        if (c == TO - 1) begin
          trapped = 1'b1;
          break;
        end
      end
      if (trapped) begin
        chk("rnd.to_trap", 32'(trap), 32'd1);
        chk("rnd.to_cause", 32'(cause), 32'd1);
        chk("rnd.to_pc", tpc, pc_exp);
        chk_perf();
        do_reset();
        pc_exp = 32'd0;
        continue;
      end
      chk("rnd.dec_state", 32'(state), 32'd1);
      chk("rnd.inst", inst, data);
      legal = lg; stall = 1'($urandom); ready = 1'($urandom);
      tick();
      if (!lg) begin
        for (int j = 0; j < 3; j++) begin
          chk("rnd.ill_trap", 32'(trap), 32'd1);
          chk("rnd.ill_cause", 32'(cause), 32'd0);
          chk("rnd.ill_pc", tpc, pc_exp);
          chk("rnd.ill_req_we", {30'd0, req, we}, 32'd0);
          chk("rnd.ill_inst", inst, data);
          ready = 1'($urandom); stall = 1'($urandom); rdata = $urandom;
          tick();
        end
        chk_perf();
        do_reset();
        pc_exp = 32'd0;
        continue;
      end
      for (int j = 0; j <= s; j++) begin
        chk("rnd.exec_state", 32'(state), 32'd2);
        chk("rnd.exec_we", 32'(we), 32'd0);
        stall = (j < s); ready = 1'($urandom);
        tick();
      end
      chk("rnd.wb_we", 32'(we), 32'd1);
      chk("rnd.wb_pc", pc, pc_exp);
      stall = 1'($urandom); ready = 1'b0;
      tick();
      pc_exp = pc_exp + 32'd4;
      chk("rnd.after_wb_we", 32'(we), 32'd0);
      chk_perf();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
